// File: rtl/clock_enable_ctrl.sv
// Activity-driven clock-enable generator feeding gated_clock.enable_in.
// Wakes on request, reports ready after settling, shuts down after an idle run via a one-cycle drain.

module clock_enable_ctrl_param_check #(
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) ();

  // Elaboration-time rejection of unsupported parameter values
  if ((IDLE_CYCLES < 1) || (IDLE_CYCLES > 255)) begin : g_bad_idle
    $error("clock_enable_ctrl: IDLE_CYCLES must be within 1..255");
  end
  if ((WAKE_CYCLES < 1) || (WAKE_CYCLES > 255)) begin : g_bad_wake
    $error("clock_enable_ctrl: WAKE_CYCLES must be within 1..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("clock_enable_ctrl: CNT_W must be at least 1");
  end

endmodule

module clock_enable_ctrl #(
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             req_in,
  input  logic             force_on_in,
  input  logic             clear_stats_in,
  output logic             enable_out,
  output logic             ready_out,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] en_cycles_out
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0]       WAKE_LAST = 8'(WAKE_CYCLES - 1);
  localparam logic [7:0]       IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           state_next_s;
  logic [7:0]       wake_cnt_r;
  logic [7:0]       wake_cnt_next_s;
  logic [7:0]       idle_cnt_r;
  logic [7:0]       idle_cnt_next_s;
  logic             enable_r;
  logic             ready_r;
  logic [CNT_W-1:0] en_cycles_r;
  logic             active_s;

  clock_enable_ctrl_param_check #(
    .IDLE_CYCLES (IDLE_CYCLES),
    .WAKE_CYCLES (WAKE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_param_check ();

  assign active_s = req_in | force_on_in;

  // Next-state and counter update logic
  always_comb begin
    state_next_s    = state_r;
    wake_cnt_next_s = wake_cnt_r;
    idle_cnt_next_s = idle_cnt_r;
    case (state_r)
      ST_OFF: begin
        if (active_s) begin
          state_next_s    = ST_WAKE;
          wake_cnt_next_s = 8'd0;
        end else begin
          state_next_s    = ST_OFF;
        end
      end
      ST_WAKE: begin
        // Requests are ignored while the gated domain settles
        if (wake_cnt_r == WAKE_LAST) begin
          state_next_s    = ST_ON;
          wake_cnt_next_s = 8'd0;
          idle_cnt_next_s = 8'd0;
        end else begin
          state_next_s    = ST_WAKE;
          wake_cnt_next_s = wake_cnt_r + 8'd1;
        end
      end
      ST_ON: begin
        if (active_s) begin
          idle_cnt_next_s = 8'd0;
        end else if (idle_cnt_r == IDLE_LAST) begin
          state_next_s    = ST_DRAIN;
          idle_cnt_next_s = 8'd0;
        end else begin
          idle_cnt_next_s = idle_cnt_r + 8'd1;
        end
      end
      ST_DRAIN: begin
        // A late request resumes without a second wake-up period
        if (active_s) begin
          state_next_s = ST_ON;
        end else begin
          state_next_s = ST_OFF;
        end
        idle_cnt_next_s = 8'd0;
      end
      default: begin
        state_next_s    = ST_OFF;
        wake_cnt_next_s = 8'd0;
        idle_cnt_next_s = 8'd0;
      end
    endcase
  end

  // State, counters and registered Moore outputs
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_r    <= ST_OFF;
      wake_cnt_r <= 8'd0;
      idle_cnt_r <= 8'd0;
      enable_r   <= 1'b0;
      ready_r    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      wake_cnt_r <= wake_cnt_next_s;
      idle_cnt_r <= idle_cnt_next_s;
      enable_r   <= (state_next_s != ST_OFF);
      ready_r    <= (state_next_s == ST_ON);
    end
  end

  // Saturating enabled-cycle statistics counter
  always_ff @(posedge clk) begin
    if (reset_in) begin
      en_cycles_r <= {CNT_W{1'b0}};
    end else if (clear_stats_in) begin
      en_cycles_r <= {CNT_W{1'b0}};
    end else if (enable_r && (en_cycles_r != CNT_MAX)) begin
      en_cycles_r <= en_cycles_r + CNT_W'(1);
    end else begin
      en_cycles_r <= en_cycles_r;
    end
  end

  assign enable_out    = enable_r;
  assign ready_out     = ready_r;
  assign state_out     = state_r;
  assign en_cycles_out = en_cycles_r;

endmodule

// File: tb/tb_clock_enable_ctrl.sv
// Scoreboard bench for clock_enable_ctrl: directed test-plan sequences plus random traffic,
// checked against a cycle-level reference model and a downstream gated register.

module tb_clock_enable_ctrl;

  localparam int IDLE = 4;
  localparam int WAKE = 2;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_in = 1'b0;
  logic          req_in = 1'b0;
  logic          force_on_in = 1'b0;
  logic          clear_stats_in = 1'b0;
  logic          enable_out;
  logic          ready_out;
  logic [1:0]    state_out;
  logic [CW-1:0] en_cycles_out;
  logic [7:0]    d_in = 8'd0;
  logic [7:0]    gq = 8'd0;

  typedef struct {
    int st;
    int en;
    int rdy;
    int cnt;
    int q;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: phase 0=off 1=waking 2=on 3=draining
  int m_phase = 0;
  int m_wake_elapsed = 0;
  int m_idle_run = 0;
  int m_cnt = 0;
  int m_q = 0;

  clock_enable_ctrl #(
    .IDLE_CYCLES (IDLE),
    .WAKE_CYCLES (WAKE),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .reset_in       (reset_in),
    .req_in         (req_in),
    .force_on_in    (force_on_in),
    .clear_stats_in (clear_stats_in),
    .enable_out     (enable_out),
    .ready_out      (ready_out),
    .state_out      (state_out),
    .en_cycles_out  (en_cycles_out)
  );

  always #5 clk = ~clk;

  // Stand-in for gated_clock: captures d_in only on enabled edges
  always @(posedge clk) begin
    if (enable_out) gq <= d_in;
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  // One clock of stimulus; model advances by the same edge and the expectation is queued
  task automatic step(input bit r, input bit f, input bit c, input bit rs);
    bit was_enabled;
    bit busy;
    exp_t e;
    @(negedge clk);
    req_in         = r;
    force_on_in    = f;
    clear_stats_in = c;
    reset_in       = rs;
    d_in           = 8'($urandom);
    was_enabled = (m_phase != 0);
    busy        = r || f;
    if (was_enabled) m_q = int'(d_in);
    if (rs) begin
      m_phase = 0; m_wake_elapsed = 0; m_idle_run = 0; m_cnt = 0;
    end else begin
      if (c) m_cnt = 0;
      else if (was_enabled && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (m_phase == 0) begin
        if (busy) begin m_phase = 1; m_wake_elapsed = 0; end
      end else if (m_phase == 1) begin
        m_wake_elapsed = m_wake_elapsed + 1;
        if (m_wake_elapsed >= WAKE) m_phase = 2;
      end else if (m_phase == 2) begin
        m_idle_run = busy ? 0 : m_idle_run + 1;
        if (m_idle_run >= IDLE) begin m_phase = 3; m_idle_run = 0; end
      end else begin
        m_phase = busy ? 2 : 0;
      end
    end
    e.st  = m_phase;
    e.en  = (m_phase != 0) ? 1 : 0;
    e.rdy = (m_phase == 2) ? 1 : 0;
    e.cnt = m_cnt;
    e.q   = m_q;
    sb_q.push_back(e);
  endtask

  task automatic steps(input int n, input bit r, input bit f);
    for (int i = 0; i < n; i++) step(r, f, 1'b0, 1'b0);
  endtask

  // Monitor: one registered output set per edge, compared against the queued expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("state_out", int'(state_out), e.st);
        check("enable_out", int'(enable_out), e.en);
        check("ready_out", int'(ready_out), e.rdy);
        check("en_cycles_out", int'(en_cycles_out), e.cnt);
        check("gated_q", int'(gq), e.q);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    // 1. reset then wake
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    steps(5, 1'b1, 1'b0);
    // 2. idle shutdown through drain to off
    steps(8, 1'b0, 1'b0);
    // 3. late cancel of shutdown
    steps(4, 1'b1, 1'b0);
    steps(3, 1'b0, 1'b0);
    steps(1, 1'b1, 1'b0);
    steps(7, 1'b0, 1'b0);
    // 4. request sampled during drain
    steps(5, 1'b1, 1'b0);
    steps(4, 1'b0, 1'b0);
    steps(1, 1'b1, 1'b0);
    steps(7, 1'b0, 1'b0);
    // 5. force-on hold, saturation, clear
    steps(300, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    steps(5, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    steps(8, 1'b0, 1'b0);
    // 6. reset during wake and during on
    steps(1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    steps(5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    steps(3, 1'b0, 1'b0);
    // random traffic with bursts and idle gaps
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 4),
           ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 2));
    end
    steps(10, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_enable_ctrl.md
Name: clock_enable_ctrl

Overview:
- Activity-driven enable generator that sits directly upstream of gated_clock and drives its enable_in.
- Opens the gated clock when work is requested.
- Holds the clock open for a wake-up settling period, then reports the gated domain ready.
- Closes the clock after a programmable number of consecutive idle cycles, via a one-cycle drain.
- Keeps a saturating count of enabled cycles for power-activity statistics.

Parameters:
- IDLE_CYCLES, 4, consecutive idle cycles in ON before shutdown; legal range 1..255.
- WAKE_CYCLES, 2, cycles enable_out is high before ready_out asserts; legal range 1..255.
- CNT_W, 8, width of the enabled-cycle statistics counter.

Ports:
- clk, input, 1, single system clock; all logic on rising edge.
- reset_in, input, 1, synchronous active-high reset.
- req_in, input, 1, activity request; high = work pending for the gated domain.
- force_on_in, input, 1, debug override; high keeps clock enabled and blocks idle shutdown.
- clear_stats_in, input, 1, synchronous clear of en_cycles_out.
- enable_out, input to gated_clock enable_in, output, 1, registered clock enable.
- ready_out, output, 1, registered; gated domain is clocked and settled.
- state_out, output, 2, encoded FSM state: OFF=0, WAKE=1, ON=2, DRAIN=3.
- en_cycles_out, output, CNT_W, saturating count of cycles with enable_out=1.

Behaviour:
- Reset is synchronous, active-high, and applies at the next rising edge; it also applies mid-operation in any state. Reset values:
  - state_out = OFF
  - enable_out = 0
  - ready_out = 0
  - en_cycles_out = 0
  - internal wake_cnt = 0
  - internal idle_cnt = 0
- All outputs are registered (Moore). enable_out = 1 in WAKE, ON and DRAIN. ready_out = 1 only in ON.
- OFF:
  - If req_in or force_on_in is sampled high, go to WAKE and clear wake_cnt.
  - enable_out rises at that same edge: one cycle of latency from request to enable.
- WAKE:
  - wake_cnt increments each cycle.
  - Go to ON after exactly WAKE_CYCLES cycles in WAKE.
  - req_in is ignored during WAKE; no shutdown from WAKE.
- ON:
  - If req_in=1 or force_on_in=1, clear idle_cnt.
  - Otherwise increment idle_cnt.
  - When idle_cnt is at IDLE_CYCLES-1 and the cycle is idle, go to DRAIN and clear idle_cnt. Net effect: DRAIN is entered after IDLE_CYCLES consecutive idle sampled cycles.
- DRAIN:
  - Lasts one cycle, with enable_out=1 and ready_out=0, so gated_clock captures its last d_in.
  - If req_in or force_on_in is sampled high in DRAIN, return to ON with no re-wake; ready_out reasserts next cycle.
  - Otherwise go to OFF; enable_out falls.
- Glitch-free enable: enable_out changes only on the rising edge of clk, never combinationally from inputs.
- en_cycles_out:
  - Increments on every cycle where enable_out=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - clear_stats_in has priority over increment and zeroes the counter at the next edge.
  - Reset has priority over clear.
- Simultaneous events:
  - force_on_in and req_in are ORed.
  - reset_in overrides every transition.
  - A req_in pulse in the exact cycle ON would have reached the idle limit cancels shutdown and clears idle_cnt.
- Counter widths: wake_cnt and idle_cnt are 8 bits and compare against the parameters.
- Illegal parameter values (0) are not supported. Add elaboration-time assertions for them.

Test Plan (IDLE_CYCLES=4, WAKE_CYCLES=2, CNT_W=8):
1. Reset and wake:
   - Stimulus: reset_in high for 2 cycles, then req_in=1 held from cycle 0.
   - Required: all outputs 0 during reset; enable_out=1 at edge 1; state WAKE for edges 1–2; ready_out=1 at edge 3 (state ON).
2. Idle shutdown:
   - Stimulus: from ON, drop req_in.
   - Required: ON for 4 idle cycles, DRAIN for 1 cycle (enable_out=1, ready_out=0), then OFF with enable_out=0. en_cycles_out equals the exact count of enabled cycles.
3. Late cancel:
   - Stimulus: in ON, idle for 3 cycles, req_in=1 on the 4th cycle, then idle.
   - Required: no DRAIN on the 4th cycle; idle count restarts; DRAIN occurs 4 idle cycles later.
4. Drain re-entry:
   - Stimulus: req_in=1 sampled during DRAIN.
   - Required: state ON next edge with ready_out=1; enable_out never drops.
5. Force and saturation:
   - Stimulus: force_on_in=1 with req_in=0 for 300 cycles.
   - Required: never leaves ON; en_cycles_out holds at 255. clear_stats_in pulse gives 0 the next cycle, then counting resumes.
6. Reset mid-operation and end-to-end:
   - Stimulus: reset_in in WAKE and in ON; separately, drive gated_clock from enable_out with random d_in.
   - Required: reset returns to OFF next edge with all counters 0. gated_clock q_out changes only on cycles where enable_out=1.
